// File: rtl/output_compare_channel.sv
// Output compare channel of a general-purpose timer: compare register with preload,
// OCREF mode logic, polarity/enable pin stage and match flag. Optional OC_CLEAR_EN adds oc_clr_i.
module output_compare_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             dir_i,
    input  logic             uev_i,
    input  logic [CNT_W-1:0] ccr_i,
    input  logic             ccr_wr_i,
    input  logic             ocpe_i,
    input  logic [2:0]       ocm_i,
    input  logic             ccp_i,
    input  logic             cce_i,
`ifdef OC_CLEAR_EN
    input  logic             oc_clr_i,
`endif
    output logic             ocref_o,
    output logic             oc_o,
    output logic             ccif_o
);

    typedef enum logic [2:0] {
        OCM_FROZEN     = 3'b000,
        OCM_ACT_MATCH  = 3'b001,
        OCM_INACT_MTCH = 3'b010,
        OCM_TOGGLE     = 3'b011,
        OCM_FORCE_LO   = 3'b100,
        OCM_FORCE_HI   = 3'b101,
        OCM_PWM1       = 3'b110,
        OCM_PWM2       = 3'b111
    } ocm_e;

    logic [CNT_W-1:0] ccr_shadow;
    logic [CNT_W-1:0] ccr_active;
    logic             match;
    logic             pwm1_level;
    logic             mode_ref;
    logic             ocref_next;
    logic             clear_now;

    // With preload on, an update event promotes the shadow value as it was before
    // any same-cycle write, so the write lands for the following period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ccr_shadow <= '0;
            ccr_active <= '0;
        end else if (ocpe_i) begin
            if (uev_i) begin
                ccr_active <= ccr_shadow;
            end
            if (ccr_wr_i) begin
                ccr_shadow <= ccr_i;
            end
        end else if (ccr_wr_i) begin
            ccr_shadow <= ccr_i;
            ccr_active <= ccr_i;
        end
    end

`ifdef OC_CLEAR_EN
    logic clr_latch;

    // The latch releases on the first update event without a clear request, and
    // mode-based output resumes on that same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clr_latch <= 1'b0;
        end else if (oc_clr_i) begin
            clr_latch <= 1'b1;
        end else if (uev_i) begin
            clr_latch <= 1'b0;
        end
    end

    assign clear_now = oc_clr_i | (clr_latch & ~uev_i);
`else
    assign clear_now = 1'b0;
`endif

    always_comb begin
        match      = (cnt_i == ccr_active);
        pwm1_level = dir_i ? (cnt_i <= ccr_active) : (cnt_i < ccr_active);
        mode_ref   = ocref_o;
        case (ocm_e'(ocm_i))
            OCM_FROZEN:     mode_ref = ocref_o;
            OCM_ACT_MATCH:  mode_ref = match ? 1'b1 : ocref_o;
            OCM_INACT_MTCH: mode_ref = match ? 1'b0 : ocref_o;
            OCM_TOGGLE:     mode_ref = match ? ~ocref_o : ocref_o;
            OCM_FORCE_LO:   mode_ref = 1'b0;
            OCM_FORCE_HI:   mode_ref = 1'b1;
            OCM_PWM1:       mode_ref = pwm1_level;
            OCM_PWM2:       mode_ref = ~pwm1_level;
            default:        mode_ref = ocref_o;
        endcase
        ocref_next = clear_now ? 1'b0 : mode_ref;
    end

    // The pin stage uses ocref_next so oc_o and ocref_o change on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ocref_o <= 1'b0;
            oc_o    <= 1'b0;
            ccif_o  <= 1'b0;
        end else begin
            ocref_o <= ocref_next;
            oc_o    <= cce_i & (ocref_next ^ ccp_i);
            ccif_o  <= match;
        end
    end

endmodule
